bigint_add_seq: RTL
===================

BIGINT_ADD_SEQ -- requirements
Module: bigint_add_seq

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 16, giving the maximum beats per operation (256 bits per beat).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port s_valid, input, 1, input beat valid.
REQ-005 SHALL have port s_ready, output, 1, input beat accepted when s_valid and s_ready are both high.
REQ-006 SHALL have port s_a, input, 256, operand A word, least-significant word first.
REQ-007 SHALL have port s_b, input, 256, operand B word.
REQ-008 SHALL have port s_first, input, 1, first beat of an operation.
REQ-009 SHALL have port s_last, input, 1, last beat of an operation.
REQ-010 SHALL have port s_sub, input, 1, operation select (0 = A+B, 1 = A-B), sampled on the first beat only.
REQ-011 SHALL have port m_valid, output, 1, result beat valid.
REQ-012 SHALL have port m_ready, input, 1, downstream accepts the result beat.
REQ-013 SHALL have port m_sum, output, 256, result word.
REQ-014 SHALL have port m_last, output, 1, final result beat of the operation.
REQ-015 SHALL have port m_carry, output, 1, final carry (add) or borrow (sub); valid only with m_last.
REQ-016 SHALL have port m_zero, output, 1, entire multi-word result is zero; valid only with m_last.
REQ-017 SHALL have port err, output, 1, one-cycle pulse on a protocol violation.

Function
REQ-018 SHALL implement states IDLE (no operation open) and BUSY (operation open, carry chained).
REQ-019 SHALL drive s_ready = !m_valid || m_ready, a single output register with no bubble under continuous flow.
REQ-020 SHALL compute each accepted beat as A + (sub ? ~B : B) + cin.
- cin = sub on a first beat.
- cin = registered carry-out of the previous beat otherwise.
REQ-021 SHALL present the result on m_sum with m_valid exactly one cycle after acceptance (latency 1).
REQ-022 SHALL hold m_sum, m_last, m_carry, m_zero and m_valid stable while m_valid && !m_ready.
REQ-023 SHALL latch s_sub on the first beat and ignore s_sub on all later beats.
REQ-024 SHALL set m_carry = carry-out for add and m_carry = ~carry-out (borrow) for sub on the last beat.
REQ-025 SHALL AND-accumulate per-beat (m_sum == 0) across the operation; m_zero is the accumulated value on the last beat.
REQ-026 SHALL transition IDLE -> BUSY on an accepted first beat without s_last.
REQ-027 SHALL stay in IDLE on an accepted beat with s_first && s_last (single-beat operation).
REQ-028 SHALL transition BUSY -> IDLE on an accepted beat with s_last.
REQ-029 SHALL handle a beat without s_first accepted in IDLE as a first beat and pulse err.
REQ-030 SHALL handle s_first accepted in BUSY as a restart: discard the chained carry, clear zero accumulation, latch the new s_sub, pulse err.
REQ-031 SHALL handle the MAX_BEATS-th beat accepted without s_last by forcing m_last = 1, returning to IDLE and pulsing err.
REQ-032 SHALL count beats in a counter of width $clog2(MAX_BEATS+1) that never wraps.
REQ-033 SHALL leave state, carry and counter unchanged on cycles with no accepted beat.

Reset
REQ-034 SHALL, on rst_n low, immediately clear state to IDLE, the carry register, the beat counter, m_valid, m_sum, m_last, m_carry, m_zero and err to 0, with m_zero's accumulator set to 1.
REQ-035 SHALL discard any in-flight operation on reset assertion mid-operation; the first beat after reset is handled per REQ-029 if s_first is low.

Structure
REQ-036 SHALL place the WORD_W = 256 constant and the state enum (IDLE, BUSY) in shared package bigint_pkg.
REQ-037 SHALL instantiate the existing cla_256bit adder as its combinational datapath; no other sub-modules.

Verification
REQ-038 Single beat add: A = 2^256-1, B = 1, first/last -> m_sum = 0, m_carry = 1, m_zero = 1, latency 1.
REQ-039 Two-beat sub: A = {1, 0}, B = {0, 1} -> beat0 m_sum = 2^256-1, beat1 m_sum = 0, m_carry = 0, m_zero = 0.
REQ-040 Backpressure: m_ready low 5 cycles during a 4-beat add -> no beat lost or duplicated, outputs stable, s_ready low while stalled.
REQ-041 s_first mid-operation at beat 2 -> err pulse, new operation with cin = s_sub, old carry discarded.
REQ-042 MAX_BEATS = 16 beats without s_last -> 16th result has m_last = 1, err pulse, next beat treated as first.
REQ-043 rst_n low asynchronously in BUSY between clock edges -> m_valid = 0 immediately, state IDLE, next beat with s_first = 0 pulses err.

Source files
------------

// File: rtl/bigint_pkg.sv
// Shared constants and state encoding for the multi-word big-integer adder.
package bigint_pkg;

  localparam int WORD_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/cla_256bit.sv
// 256-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_256bit
  import bigint_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int NG = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [NG-1:0]     grp_g;
  logic [NG-1:0]     grp_p;
  logic [NG-1:0]     grp_cin;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] cc;

    assign gg = g[4*j +: 4];
    assign pp = p[4*j +: 4];

    assign cc[0] = grp_cin[j];
    assign cc[1] = gg[0] | (pp[0] & grp_cin[j]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_cin[j]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & grp_cin[j]);

    assign grp_g[j] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p[j] = &pp;

    assign sum[4*j +: 4] = pp ^ cc;
  end

  // Group carries ripple through the precomputed group generate/propagate terms.
  always_comb begin
    logic c;
    c = cin;
    grp_cin = '0;
    for (int j = 0; j < NG; j++) begin
      grp_cin[j] = c;
      c = grp_g[j] | (grp_p[j] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/bigint_add_seq.sv
// Streaming multi-word add/subtract: one 256-bit beat per cycle, carry chained
// across beats, single output register with ready/valid backpressure.
module bigint_add_seq
  import bigint_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_a,
  input  logic [WORD_W-1:0] s_b,
  input  logic              s_first,
  input  logic              s_last,
  input  logic              s_sub,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_sum,
  output logic              m_last,
  output logic              m_carry,
  output logic              m_zero,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t            state;
  state_t            state_nxt;
  logic              carry_p1;
  logic              sub_p1;
  logic              zacc_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic              acc_p0;
  logic              first_p0;
  logic              sub_p0;
  logic              cin_p0;
  logic [WORD_W-1:0] b_p0;
  logic [WORD_W-1:0] sum_p0;
  logic              cout_p0;
  logic [CNT_W-1:0]  cnt_nxt_p0;
  logic              force_p0;
  logic              last_p0;
  logic              zero_p0;
  logic              viol_p0;

  // Stage p0: accepted input beat through the adder
  assign s_ready  = !m_valid || m_ready;
  assign acc_p0   = s_valid && s_ready;
  // Any beat arriving with no operation open starts a new one.
  assign first_p0 = s_first || (state == IDLE);
  assign sub_p0   = first_p0 ? s_sub : sub_p1;
  assign cin_p0   = first_p0 ? s_sub : carry_p1;
  assign b_p0     = sub_p0 ? ~s_b : s_b;

  cla_256bit u_cla (
    .a    (s_a),
    .b    (b_p0),
    .cin  (cin_p0),
    .sum  (sum_p0),
    .cout (cout_p0)
  );

  assign cnt_nxt_p0 = first_p0 ? CNT_W'(1) : cnt_p1 + CNT_W'(1);
  assign force_p0   = !s_last && (cnt_nxt_p0 == CNT_W'(MAX_BEATS));
  assign last_p0    = s_last || force_p0;
  assign zero_p0    = (first_p0 ? 1'b1 : zacc_p1) & (sum_p0 == '0);
  assign viol_p0    = ((state == IDLE) && !s_first) || ((state == BUSY) && s_first) || force_p0;

  always_comb begin
    state_nxt = state;
    if (acc_p0) begin
      state_nxt = last_p0 ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: chained operation state and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_p1 <= 1'b0;
      sub_p1   <= 1'b0;
      zacc_p1  <= 1'b1;
      cnt_p1   <= '0;
      m_valid  <= 1'b0;
      m_sum    <= '0;
      m_last   <= 1'b0;
      m_carry  <= 1'b0;
      m_zero   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= acc_p0 && viol_p0;
      if (acc_p0) begin
        carry_p1 <= cout_p0;
        sub_p1   <= sub_p0;
        zacc_p1  <= last_p0 ? 1'b1 : zero_p0;
        cnt_p1   <= last_p0 ? '0 : cnt_nxt_p0;
        m_valid  <= 1'b1;
        m_sum    <= sum_p0;
        m_last   <= last_p0;
        m_carry  <= last_p0 & (cout_p0 ^ sub_p0);
        m_zero   <= last_p0 & zero_p0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
